// File: rtl/mem_bus_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores over a variable-latency data bus,
// extends load data and stalls the front end until the access completes.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic        mem_write_m,
    input  logic        mem_read_m,
    input  logic [2:0]  funct3_m,
    output logic [31:0] rd_data,
    output logic        stall_m,
    output logic        misaligned_m,
    output logic        bus_err_m,
    mem_bus_if.master   bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   rd_n, ld_data, cap_data;
    logic [15:0]   ld_half;
    logic [7:0]    ld_byte;
    logic          access, is_store, is_byte, is_half, misaligned;
    logic          req, stall, err_n, mis_n;

    // A store wins when both read and write are asserted
    assign access   = mem_read_m | mem_write_m;
    assign is_store = mem_write_m;
    assign is_byte  = funct3_m[1:0] == 2'b00;
    assign is_half  = funct3_m[1:0] == 2'b01;

    assign misaligned = (is_half & alu_result_m[0])
                      | (~is_byte & ~is_half & (alu_result_m[1:0] != 2'b00));

    assign ld_byte = 8'(bus.bus_rdata >> {alu_result_m[1:0], 3'b000});
    assign ld_half = alu_result_m[1] ? bus.bus_rdata[31:16]
                                     : bus.bus_rdata[15:0];

    always_comb begin
        unique case (funct3_m)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus.bus_rdata;
        endcase
    end

    assign cap_data = is_store ? 32'h0 : ld_data;

    assign bus.bus_we   = is_store;
    assign bus.bus_addr = {alu_result_m[31:2], 2'b00};

    always_comb begin
        bus.bus_wstrb = 4'b0000;
        bus.bus_wdata = write_data_m;
        if (is_store) begin
            unique case (1'b1)
                is_byte: begin
                    bus.bus_wstrb = 4'b0001 << alu_result_m[1:0];
                    bus.bus_wdata = {4{write_data_m[7:0]}};
                end
                is_half: begin
                    bus.bus_wstrb = alu_result_m[1] ? 4'b1100 : 4'b0011;
                    bus.bus_wdata = {2{write_data_m[15:0]}};
                end
                default: bus.bus_wstrb = 4'b1111;
            endcase
        end
    end

    // cnt counts stalled cycles, so the timeout bounds total stall length
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_n    = rd_data;
        req     = 1'b0;
        stall   = 1'b0;
        err_n   = 1'b0;
        mis_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!access) begin
                    rd_n = 32'h0;
                end else if (misaligned) begin
                    mis_n = 1'b1;
                    rd_n  = 32'h0;
                end else begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (bus.bus_ack) begin
                        state_n = DONE;
                        rd_n    = cap_data;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CW'(1);
                    end
                end
            end
            WAIT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (bus.bus_ack) begin
                    state_n = DONE;
                    rd_n    = cap_data;
                end else if (cnt >= CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    rd_n    = 32'h0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset must drop the request at once, even mid-access
    assign bus.bus_req = req & ~reset;
    assign stall_m     = stall & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_data      <= 32'h0;
            misaligned_m <= 1'b0;
            bus_err_m    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rd_data      <= rd_n;
            misaligned_m <= mis_n;
            bus_err_m    <= err_n;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan steps plus random accesses
// checked against a byte-lane reference model.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_m, write_data_m, rd_data;
    logic        mem_write_m, mem_read_m;
    logic        stall_m, misaligned_m, bus_err_m;
    logic [2:0]  funct3_m;
    int          checks = 0;
    int          errors = 0;

    mem_bus_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .mem_write_m  (mem_write_m),
        .mem_read_m   (mem_read_m),
        .funct3_m     (funct3_m),
        .rd_data      (rd_data),
        .stall_m      (stall_m),
        .misaligned_m (misaligned_m),
        .bus_err_m    (bus_err_m),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] addr,
                                               input logic [31:0] word);
        int     sz;
        longint off, span, v;
        sz = acc_size(f3);
        if (sz == 4) return word;
        off  = longint'(addr % 32'd4);
        span = longint'(1) << (8 * sz);
        v    = (longint'(word) >> (8 * off)) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_strb(input int sz,
                                              input logic [31:0] addr);
        logic [3:0] m;
        int         off;
        m   = 4'b0000;
        off = (sz == 4) ? 0 : int'(addr % 32'd4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input int sz,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    // lat = stall cycle (1-based) carrying the ack; 0 = never ack
    task automatic run_access(input logic rd, input logic wr,
                              input logic [2:0] f3,
                              input logic [31:0] addr,
                              input logic [31:0] wd,
                              input logic [31:0] word,
                              input int lat);
        int          sz, stalls, exp_stalls;
        logic        mis, issued;
        logic [31:0] exp_rd;
        sz         = acc_size(f3);
        mis        = (rd | wr) && (addr % 32'(sz) != 0);
        issued     = (rd | wr) && !mis;
        exp_stalls = !issued ? 0 : (lat == 0 ? 16 : lat);
        exp_rd     = (issued && !wr && lat != 0) ? model_load(f3, addr, word)
                                                 : 32'h0;
        mem_read_m   = rd;
        mem_write_m  = wr;
        funct3_m     = f3;
        alu_result_m = addr;
        write_data_m = wd;
        bus.bus_rdata = word;
        stalls = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.bus_ack = (lat != 0 && cyc == lat);
            @(negedge clk);
            if (!stall_m) break;
            stalls++;
            check("req", 32'(bus.bus_req), 32'd1);
            check("addr", bus.bus_addr, {addr[31:2], 2'b00});
            check("we", 32'(bus.bus_we), 32'(wr));
            check("wstrb", 32'(bus.bus_wstrb),
                  wr ? 32'(model_strb(sz, addr)) : 32'd0);
            if (wr) check("wdata", bus.bus_wdata, model_wdata(sz, wd));
            @(posedge clk); #1;
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        bus.bus_ack = 1'b0;
        check("req_low", 32'(bus.bus_req), 32'd0);
        if (issued) begin
            check("rd_data", rd_data, exp_rd);
            check("bus_err", 32'(bus_err_m), 32'(lat == 0));
        end
        @(posedge clk); #1;
        mem_read_m   = 1'b0;
        mem_write_m  = 1'b0;
        alu_result_m = $urandom;
        @(negedge clk);
        check("misaligned", 32'(misaligned_m), 32'(mis));
        check("err_pulse", 32'(bus_err_m), 32'd0);
        check("bubble_stall", 32'(stall_m), 32'd0);
        check("rd_after", rd_data, issued ? exp_rd : 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_bubble", rd_data, 32'h0);
        check("mis_pulse", 32'(misaligned_m), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset         = 1'b1;
        mem_read_m    = 1'b0;
        mem_write_m   = 1'b0;
        funct3_m      = 3'b010;
        alu_result_m  = 32'h0;
        write_data_m  = 32'h0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        #2;
        check("rst_req", 32'(bus.bus_req), 32'd0);
        check("rst_stall", 32'(stall_m), 32'd0);
        check("rst_rd", rd_data, 32'h0);
        check("rst_mis", 32'(misaligned_m), 32'd0);
        check("rst_err", 32'(bus_err_m), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1);
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80000000, 4);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80000000, 4);
        run_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 2);
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1);
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFE, 1);
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h55555555, 0);
        run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 3);
        run_access(1, 1, 3'b000, 32'h401, 32'hA5, 32'h0, 2);
        run_access(1, 0, 3'b111, 32'h500, 32'h0, 32'h87654321, 16);

        mem_read_m    = 1'b1;
        mem_write_m   = 1'b0;
        funct3_m      = 3'b010;
        alu_result_m  = 32'h200;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'hDEADBEEF;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mw_stall", 32'(stall_m), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mw_rst_req", 32'(bus.bus_req), 32'd0);
        check("mw_rst_stall", 32'(stall_m), 32'd0);
        check("mw_rst_rd", rd_data, 32'h0);
        @(posedge clk); #1;
        reset      = 1'b0;
        mem_read_m = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 32'(stall_m), 32'd0);
        check("post_rst_err", 32'(bus_err_m), 32'd0);
        @(posedge clk); #1;
        run_access(1, 0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 2);

        for (int n = 0; n < 60; n++) begin
            logic        rd, wr;
            logic [2:0]  f;
            logic [31:0] a;
            int          k, lat;
            k  = int'($urandom_range(0, 9));
            rd = (k >= 1 && k <= 4) || k == 9;
            wr = k >= 5;
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~32'(acc_size(f) - 1);
            lat = ($urandom_range(0, 14) == 0) ? 0
                                               : int'($urandom_range(1, 5));
            run_access(rd, wr, f, a, $urandom, $urandom, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
